// File: rtl/dsp_mac_tdm_pkg.sv
// rtl/dsp_mac_tdm_pkg.sv - shared op encoding, channel width and saturation helpers for dsp_mac_tdm
//
// Package dsp_pkg
//   OP_SUB / OP_PRE / OP_ACC : bit positions inside the 3-bit op field
//   calc_ch_w(nch)           : channel index width, never less than 1
//   saturate(neg, pw)        : most negative (neg=1) or most positive (neg=0) pw-bit
//                              two's-complement value, zero-padded to SAT_MAX_W bits
package dsp_pkg;

    localparam int OP_SUB    = 0;
    localparam int OP_PRE    = 1;
    localparam int OP_ACC    = 2;
    localparam int SAT_MAX_W = 128;

    function automatic int calc_ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] saturate(input logic neg, input int pw);
        logic [SAT_MAX_W-1:0] r;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < pw - 1) begin
                r[i] = ~neg;
            end else if (i == pw - 1) begin
                r[i] = neg;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_mac_tdm_preadd_mult.sv
// rtl/dsp_mac_tdm_preadd_mult.sv - operand registers, signed pre-adder and multiplier with optional M stage
//
// Module dsp_preadd_mult
//   clk     in   1                 clock, rising edge
//   rst     in   1                 asynchronous reset, active-high
//   load    in   1                 capture a/b/d/op_pre into the operand registers
//   a       in   A_W               signed multiplicand
//   b       in   B_W               signed pre-adder operand / bypass multiplier
//   d       in   B_W               signed pre-adder operand
//   op_pre  in   2                 [OP_SUB] subtract (d-b), [OP_PRE] use pre-adder (else b)
//   prod    out  A_W+B_W+1         signed product; registered when MREG=1, else combinational
module dsp_preadd_mult
    import dsp_pkg::*;
#(
    parameter int A_W  = 18,
    parameter int B_W  = 18,
    parameter int MREG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic [B_W-1:0]     d,
    input  logic [1:0]         op_pre,
    output logic [A_W+B_W:0]   prod
);

    localparam int PRE_W  = B_W + 1;
    localparam int PROD_W = A_W + B_W + 1;

    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic [B_W-1:0] d_q, d_d;
    logic [1:0]     op_q, op_d;

    // Operand registers hold their contents when no sample is accepted.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        d_d  = d_q;
        op_d = op_q;
        if (load) begin
            a_d  = a;
            b_d  = b;
            d_d  = d;
            op_d = op_pre;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            d_q  <= '0;
            op_q <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            d_q  <= d_d;
            op_q <= op_d;
        end
    end

    logic signed [PRE_W-1:0]  b_ext, d_ext, pre;
    logic signed [PROD_W-1:0] a_ext, pre_ext, prod_c;

    // Pre-adder is one bit wider than its operands so d+b / d-b never wrap.
    // Both multiplier operands are widened to the product width first, so the
    // truncated product equals the exact signed product.
    always_comb begin
        b_ext = {b_q[B_W-1], b_q};
        d_ext = {d_q[B_W-1], d_q};
        if (op_q[OP_PRE]) begin
            pre = op_q[OP_SUB] ? (d_ext - b_ext) : (d_ext + b_ext);
        end else begin
            pre = b_ext;
        end
        a_ext   = {{(PROD_W - A_W){a_q[A_W-1]}}, a_q};
        pre_ext = {{(PROD_W - PRE_W){pre[PRE_W-1]}}, pre};
        prod_c  = a_ext * pre_ext;
    end

    generate
        if (MREG != 0) begin : g_mreg
            logic [PROD_W-1:0] m_q, m_d;

            always_comb begin
                m_d = prod_c;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_q <= '0;
                end else begin
                    m_q <= m_d;
                end
            end

            assign prod = m_q;
        end else begin : g_no_mreg
            assign prod = prod_c;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_tdm.sv
// rtl/dsp_mac_tdm.sv - signed pre-add/multiply/accumulate slice with NCH time-multiplexed accumulators
//
// Module dsp_mac_tdm (optional feature macro: DSP_MAC_SAT_EN, saturating post-add)
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   in_valid   in   1        sample qualifier
//   in_ch      in   CH_W     target accumulator channel; values >= NCH are dropped
//   a          in   A_W      signed multiplicand
//   b          in   B_W      signed pre-adder operand / bypass multiplier
//   d          in   B_W      signed pre-adder operand
//   op         in   3        [0] subtract d-b, [1] use pre-adder, [2] accumulate (else load)
//   clr        in   1        synchronous clear of all accumulators
//   out_valid  out  1        one pulse per accepted sample
//   out_ch     out  CH_W     channel of the result
//   p          out  P_W      new accumulator value
//   ovf        out  1        signed overflow of this result's post-add
module dsp_mac_tdm
    import dsp_pkg::*;
#(
    parameter int  A_W  = 18,
    parameter int  B_W  = 18,
    parameter int  P_W  = 48,
    parameter int  NCH  = 4,
    parameter int  MREG = 1,
    localparam int CH_W = calc_ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [B_W-1:0]   d,
    input  logic [2:0]       op,
    input  logic             clr,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [P_W-1:0]   p,
    output logic             ovf
);

    localparam int              PROD_W = A_W + B_W + 1;
    localparam logic [CH_W:0]   NCH_L  = (CH_W + 1)'(NCH);

    generate
        if (P_W < PROD_W) begin : g_pw_check
            $error("dsp_mac_tdm: P_W must be at least A_W+B_W+1");
        end
        if (NCH < 1) begin : g_nch_check
            $error("dsp_mac_tdm: NCH must be at least 1");
        end
    endgenerate

    logic accept;
    assign accept = in_valid && ({1'b0, in_ch} < NCH_L);

    logic [PROD_W-1:0] prod;

    dsp_preadd_mult #(
        .A_W  (A_W),
        .B_W  (B_W),
        .MREG (MREG)
    ) u_preadd_mult (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .a      (a),
        .b      (b),
        .d      (d),
        .op_pre (op[OP_PRE:OP_SUB]),
        .prod   (prod)
    );

    // Channel/accumulate tags travel beside the operands so they line up
    // with the product at the post-adder.
    logic            v1_q, v1_d;
    logic [CH_W-1:0] ch1_q, ch1_d;
    logic            acc1_q, acc1_d;

    always_comb begin
        v1_d   = accept;
        ch1_d  = ch1_q;
        acc1_d = acc1_q;
        if (accept) begin
            ch1_d  = in_ch;
            acc1_d = op[OP_ACC];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            ch1_q  <= '0;
            acc1_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            ch1_q  <= ch1_d;
            acc1_q <= acc1_d;
        end
    end

    logic            v_s3;
    logic [CH_W-1:0] ch_s3;
    logic            acc_s3;

    generate
        if (MREG != 0) begin : g_tag_m
            logic            v2_q, v2_d;
            logic [CH_W-1:0] ch2_q, ch2_d;
            logic            acc2_q, acc2_d;

            always_comb begin
                v2_d   = v1_q;
                ch2_d  = ch1_q;
                acc2_d = acc1_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2_q   <= 1'b0;
                    ch2_q  <= '0;
                    acc2_q <= 1'b0;
                end else begin
                    v2_q   <= v2_d;
                    ch2_q  <= ch2_d;
                    acc2_q <= acc2_d;
                end
            end

            assign v_s3   = v2_q;
            assign ch_s3  = ch2_q;
            assign acc_s3 = acc2_q;
        end else begin : g_tag_direct
            assign v_s3   = v1_q;
            assign ch_s3  = ch1_q;
            assign acc_s3 = acc1_q;
        end
    endgenerate

    logic [P_W-1:0]          acc_q [NCH];
    logic [P_W-1:0]          acc_d [NCH];
    logic signed [PROD_W-1:0] prod_s;
    logic [P_W-1:0]          prod_ext, acc_sel, acc_in, sum, res;
    logic                    ovf_c;
`ifdef DSP_MAC_SAT_EN
    logic [SAT_MAX_W-1:0]    sat_val;
`endif

    assign prod_s = prod;

    // Post-adder. The bank is read and written in this same stage, so a
    // same-channel sample one cycle behind sees this result directly.
    // A coincident clr turns the sample into a load.
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_s3 == CH_W'(i)) begin
                acc_sel = acc_q[i];
            end
        end
        acc_in   = (acc_s3 && !clr) ? acc_sel : '0;
        prod_ext = P_W'(prod_s);
        sum      = acc_in + prod_ext;
        ovf_c    = (acc_in[P_W-1] == prod_ext[P_W-1]) && (sum[P_W-1] != acc_in[P_W-1]);
        res      = sum;
`ifdef DSP_MAC_SAT_EN
        // On overflow both operands share a sign; clamp toward it.
        sat_val = saturate(acc_in[P_W-1], P_W);
        if (ovf_c) begin
            res = sat_val[P_W-1:0];
        end
`endif
    end

    // clr wipes every channel; a valid sample in this stage writes after it.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            acc_d[i] = clr ? '0 : acc_q[i];
        end
        if (v_s3) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_s3 == CH_W'(i)) begin
                    acc_d[i] = res;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    logic            out_valid_q, out_valid_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [P_W-1:0]  p_q, p_d;
    logic            ovf_q, ovf_d;

    // Bubbles leave the last result on p/out_ch/ovf.
    always_comb begin
        out_valid_d = v_s3;
        out_ch_d    = out_ch_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        if (v_s3) begin
            out_ch_d = ch_s3;
            p_d      = res;
            ovf_d    = ovf_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign p         = p_q;
    assign ovf       = ovf_q;

endmodule
